// File: rtl/carga_byte_mem.sv
// carga_byte_mem: byte-load fetch stage between the data-memory port and the
// 8-to-32 sign extender. Runs a req/ack handshake with a bounded wait, picks
// the addressed little-endian byte lane and reports success or timeout.
module carga_byte_mem #(
   parameter int TIMEOUT = 15,
   parameter int CW      = 8
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        Inicio,
   input  logic [31:0] Direccion,
   input  logic        ConSigno,
   output logic        Mem_Req,
   output logic [31:0] Mem_Dir,
   input  logic        Mem_Ack,
   input  logic [31:0] Mem_Dato,
   output logic [7:0]  Entrada,
   output logic        Signo,
   output logic        Valido,
   output logic        Error,
   output logic        Ocupado
);

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      LECTURA = 2'd1,
      LISTO   = 2'd2,
      FALLO   = 2'd3
   } state_t;

   // Counter value reached in the final request cycle before giving up.
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] wait_count;
   logic [1:0]    lane;
   logic          sign_req;
   logic [7:0]    lane_byte;

   // State register; reset aborts any outstanding request immediately.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= REPOSO;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; an acknowledge on the last wait cycle beats the timeout.
   always_comb begin
      next_state = state;
      case (state)
         REPOSO: begin
            if (Inicio) begin
               next_state = LECTURA;
            end
         end
         LECTURA: begin
            if (Mem_Ack) begin
               next_state = LISTO;
            end else if (wait_count == LAST_WAIT) begin
               next_state = FALLO;
            end
         end
         LISTO:   next_state = REPOSO;
         FALLO:   next_state = REPOSO;
         default: next_state = REPOSO;
      endcase
   end

   // Handshake and status outputs are pure decodes of the registered state.
   always_comb begin
      Mem_Req = 1'b0;
      Valido  = 1'b0;
      Error   = 1'b0;
      Ocupado = 1'b1;
      case (state)
         REPOSO:  Ocupado = 1'b0;
         LECTURA: Mem_Req = 1'b1;
         LISTO:   Valido  = 1'b1;
         FALLO:   Error   = 1'b1;
         default: Ocupado = 1'b0;
      endcase
   end

   // Little-endian byte lane selected by the latched low address bits.
   always_comb begin
      lane_byte = Mem_Dato[7:0];
      case (lane)
         2'd0: lane_byte = Mem_Dato[7:0];
         2'd1: lane_byte = Mem_Dato[15:8];
         2'd2: lane_byte = Mem_Dato[23:16];
         2'd3: lane_byte = Mem_Dato[31:24];
         default: lane_byte = Mem_Dato[7:0];
      endcase
   end

   // Request latching, wait counting and result capture; the result only
   // changes on an acknowledged read, so timeouts leave it untouched.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wait_count <= '0;
         lane       <= 2'd0;
         sign_req   <= 1'b0;
         Mem_Dir    <= 32'h0000_0000;
         Entrada    <= 8'h00;
         Signo      <= 1'b0;
      end else begin
         case (state)
            REPOSO: begin
               if (Inicio) begin
                  lane       <= Direccion[1:0];
                  sign_req   <= ConSigno;
                  Mem_Dir    <= {Direccion[31:2], 2'b00};
                  wait_count <= '0;
               end
            end
            LECTURA: begin
               if (Mem_Ack) begin
                  Entrada <= lane_byte;
                  Signo   <= sign_req;
               end else if (wait_count != LAST_WAIT) begin
                  wait_count <= wait_count + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_carga_byte_mem.sv
// tb_carga_byte_mem: randomized self-checking bench for carga_byte_mem.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_carga_byte_mem;

   localparam int TIMEOUT = 15;
   localparam int NO_ACK  = 1000;

   logic        Clk;
   logic        Reset_n;
   logic        Inicio;
   logic [31:0] Direccion;
   logic        ConSigno;
   logic        Mem_Req;
   logic [31:0] Mem_Dir;
   logic        Mem_Ack;
   logic [31:0] Mem_Dato;
   logic [7:0]  Entrada;
   logic        Signo;
   logic        Valido;
   logic        Error;
   logic        Ocupado;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference result of the most recent successful load.
   logic [7:0] exp_entrada = 8'h00;
   logic       exp_signo   = 1'b0;

   carga_byte_mem #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .Inicio    (Inicio),
      .Direccion (Direccion),
      .ConSigno  (ConSigno),
      .Mem_Req   (Mem_Req),
      .Mem_Dir   (Mem_Dir),
      .Mem_Ack   (Mem_Ack),
      .Mem_Dato  (Mem_Dato),
      .Entrada   (Entrada),
      .Signo     (Signo),
      .Valido    (Valido),
      .Error     (Error),
      .Ocupado   (Ocupado)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Byte n of a little-endian word.
   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] a);
      logic [31:0] shifted;
      shifted = w >> (8 * int'(a));
      return shifted[7:0];
   endfunction

   // What SignExtend_8_32 would produce from the current outputs.
   function automatic logic [31:0] extend(input logic [7:0] b, input logic s);
      return s ? {{24{b[7]}}, b} : {24'h0, b};
   endfunction

   // One complete load: delay = wait cycles before Mem_Ack (>= TIMEOUT means none).
   task automatic run_load(input logic [31:0] addr, input logic sgn, input logic [31:0] dato,
                           input int delay, input bit noise, input string name);
      int reqs;
      int exp_reqs;
      int early_flags;
      Inicio = 1'b1; Direccion = addr; ConSigno = sgn; Mem_Ack = 1'b0;
      @(posedge Clk); @(negedge Clk);
      Inicio = 1'b0; Direccion = $urandom; ConSigno = 1'($urandom);
      n_checks++;
      if (Mem_Dir !== {addr[31:2], 2'b00} || Ocupado !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL %s mem_dir: got %h ocupado %b, want %h ocupado 1", name, Mem_Dir, Ocupado, {addr[31:2], 2'b00});
      end
      reqs = 0;
      early_flags = 0;
      exp_reqs = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
      for (int c = 0; c < TIMEOUT + 3 && Mem_Req === 1'b1; c++) begin
         if (Valido !== 1'b0 || Error !== 1'b0) early_flags++;
         if (reqs == delay) begin
            Mem_Ack = 1'b1; Mem_Dato = dato;
         end else begin
            Mem_Ack = 1'b0; Mem_Dato = $urandom;
         end
         if (noise) begin
            Inicio = 1'($urandom); Direccion = $urandom; ConSigno = 1'($urandom);
         end
         reqs++;
         @(posedge Clk); @(negedge Clk);
      end
      Mem_Ack = 1'b0; Inicio = 1'b0;
      n_checks++;
      if (reqs != exp_reqs || early_flags != 0) begin
         n_fail++;
         $display("[TB] FAIL %s req_cycles: got %0d (early flags %0d), want %0d", name, reqs, early_flags, exp_reqs);
      end
      if (delay < TIMEOUT) begin
         exp_entrada = byte_of(dato, addr[1:0]);
         exp_signo   = sgn;
      end
      n_checks++;
      if (Valido !== (delay < TIMEOUT) || Error !== (delay >= TIMEOUT)) begin
         n_fail++;
         $display("[TB] FAIL %s status: got valido %b error %b, want valido %b error %b",
                  name, Valido, Error, delay < TIMEOUT, delay >= TIMEOUT);
      end
      n_checks++;
      if (Entrada !== exp_entrada || Signo !== exp_signo) begin
         n_fail++;
         $display("[TB] FAIL %s result: got %h/%b, want %h/%b", name, Entrada, Signo, exp_entrada, exp_signo);
      end
      @(posedge Clk); @(negedge Clk);
      n_checks++;
      if (Ocupado !== 1'b0 || Valido !== 1'b0 || Error !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL %s return_idle: got ocupado %b valido %b error %b, want 0 0 0", name, Ocupado, Valido, Error);
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; Inicio = 1'b0; Direccion = 32'h0; ConSigno = 1'b0;
      Mem_Ack = 1'b0; Mem_Dato = 32'h0;
      #3;
      n_checks++;
      if (Mem_Req !== 1'b0 || Valido !== 1'b0 || Error !== 1'b0 || Ocupado !== 1'b0 ||
          Mem_Dir !== 32'h0 || Entrada !== 8'h00 || Signo !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_state: got req %b val %b err %b ocu %b dir %h ent %h sig %b, want all zero",
                  Mem_Req, Valido, Error, Ocupado, Mem_Dir, Entrada, Signo);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
   endtask

   task automatic test_zero_wait_lb();
      run_load(32'h0000_1002, 1'b1, 32'h12C1_5678, 0, 1'b0, "zero_wait_lb");
      n_checks++;
      if (Entrada !== 8'hC1 || extend(Entrada, Signo) !== 32'hFFFF_FFC1) begin
         n_fail++;
         $display("[TB] FAIL lb_extend: got %h, want FFFFFFC1", extend(Entrada, Signo));
      end
   endtask

   task automatic test_lanes_lbu();
      logic [7:0] want [4];
      want[0] = 8'hFF; want[1] = 8'h59; want[2] = 8'h18; want[3] = 8'h81;
      for (int i = 0; i < 4; i++) begin
         run_load(32'h0000_2000 + 32'(i), 1'b0, 32'h8118_59FF, 0, 1'b0, "lane_lbu");
         n_checks++;
         if (Entrada !== want[i] || Signo !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL lane_%0d_const: got %h/%b, want %h/0", i, Entrada, Signo, want[i]);
         end
      end
      n_checks++;
      if (extend(Entrada, Signo) !== 32'h0000_0081) begin
         n_fail++;
         $display("[TB] FAIL lbu_extend: got %h, want 00000081", extend(Entrada, Signo));
      end
   endtask

   task automatic test_wait_and_ignored_inicio();
      run_load(32'h0000_3001, 1'b1, 32'hA5B6_C7D8, 3, 1'b1, "wait3_noise");
   endtask

   task automatic test_timeout();
      run_load(32'h0000_4003, 1'b1, 32'h0, NO_ACK, 1'b0, "timeout");
      run_load(32'h0000_4001, 1'b1, 32'h0000_9E00, TIMEOUT - 1, 1'b0, "ack_last_cycle");
   endtask

   task automatic test_ack_idle();
      for (int i = 0; i < 3; i++) begin
         Mem_Ack = 1'b1; Mem_Dato = $urandom;
         @(posedge Clk); @(negedge Clk);
         n_checks++;
         if (Ocupado !== 1'b0 || Valido !== 1'b0 || Entrada !== exp_entrada || Signo !== exp_signo) begin
            n_fail++;
            $display("[TB] FAIL ack_idle: got ocu %b val %b ent %h sig %b, want 0 0 %h %b",
                     Ocupado, Valido, Entrada, Signo, exp_entrada, exp_signo);
         end
      end
      Mem_Ack = 1'b0;
   endtask

   task automatic test_reset_mid_load();
      Inicio = 1'b1; Direccion = 32'h0000_5002; ConSigno = 1'b1; Mem_Ack = 1'b0;
      @(posedge Clk); @(negedge Clk);
      Inicio = 1'b0;
      repeat (3) begin
         @(posedge Clk); @(negedge Clk);
      end
      Reset_n = 1'b0;
      #1;
      exp_entrada = 8'h00; exp_signo = 1'b0;
      n_checks++;
      if (Mem_Req !== 1'b0 || Ocupado !== 1'b0 || Entrada !== 8'h00 || Signo !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_mid: got req %b ocu %b ent %h sig %b, want 0 0 00 0", Mem_Req, Ocupado, Entrada, Signo);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      Mem_Ack = 1'b1; Mem_Dato = 32'hFFFF_FFFF;
      repeat (2) begin
         @(posedge Clk); @(negedge Clk);
         n_checks++;
         if (Ocupado !== 1'b0 || Valido !== 1'b0 || Error !== 1'b0 || Entrada !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL reset_late_ack: got ocu %b val %b err %b ent %h, want 0 0 0 00", Ocupado, Valido, Error, Entrada);
         end
      end
      Mem_Ack = 1'b0;
      run_load(32'h0000_5003, 1'b0, 32'h7700_0000, 1, 1'b0, "after_reset");
   endtask

   // With Inicio held and memory always acknowledging, a load is accepted in
   // every idle cycle and completes two cycles later, i.e. one every 3 cycles.
   task automatic test_back_to_back();
      logic [31:0] addr_hist [32];
      logic        sgn_hist  [32];
      logic [31:0] dato;
      int          n_valid;
      dato = $urandom;
      n_valid = 0;
      Mem_Ack = 1'b1; Mem_Dato = dato; Inicio = 1'b1;
      for (int k = 0; k < 24; k++) begin
         addr_hist[k] = $urandom; sgn_hist[k] = 1'($urandom);
         Direccion = addr_hist[k]; ConSigno = sgn_hist[k];
         if (k >= 1) begin
            n_checks++;
            if (Valido !== (k % 3 == 2) || Mem_Req !== (k % 3 == 1)) begin
               n_fail++;
               $display("[TB] FAIL b2b_pattern cycle %0d: got valido %b req %b, want %b %b",
                        k, Valido, Mem_Req, k % 3 == 2, k % 3 == 1);
            end
            if (k % 3 == 2) begin
               n_valid++;
               exp_entrada = byte_of(dato, addr_hist[k-2][1:0]);
               exp_signo   = sgn_hist[k-2];
               n_checks++;
               if (Entrada !== exp_entrada || Signo !== exp_signo) begin
                  n_fail++;
                  $display("[TB] FAIL b2b_result cycle %0d: got %h/%b, want %h/%b", k, Entrada, Signo, exp_entrada, exp_signo);
               end
            end
         end
         @(posedge Clk); @(negedge Clk);
      end
      Inicio = 1'b0; Mem_Ack = 1'b0;
      @(posedge Clk); @(negedge Clk);
      n_checks++;
      if (Ocupado !== 1'b0 || n_valid != 8) begin
         n_fail++;
         $display("[TB] FAIL b2b_end: got ocupado %b loads %0d, want 0 8", Ocupado, n_valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         run_load($urandom, 1'($urandom), $urandom, int'($urandom_range(0, TIMEOUT + 2)),
                  bit'($urandom), "random");
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait_lb();
      test_lanes_lbu();
      test_wait_and_ignored_inicio();
      test_timeout();
      test_ack_idle();
      test_reset_mid_load();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
